// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default address width, pointer type and Gray helpers.
package fifo_pkg;

  localparam int ADDRSIZE = 4;

  typedef logic [ADDRSIZE:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return (b >> 1) ^ b;
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = '0;
    for (int i = 0; i < ADDRSIZE + 1; i++) b[i] = ^(g >> i);
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter, shared by the write-full and read-empty generators.
module gray2bin_conv #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) bin[i] = ^(gray >> i);
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer / full-flag generator for the async FIFO.
// Optional walmost_full output enabled by defining FIFO_ALMOST_FULL_EN.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = fifo_pkg::ADDRSIZE,
  parameter int AFULL_THRESH = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic [ADDRSIZE:0]   wcount,
`ifdef FIFO_ALMOST_FULL_EN
  output logic                walmost_full,
`endif
  output logic                woverflow
);

  if (AFULL_THRESH < 1 || AFULL_THRESH > (1 << ADDRSIZE)) begin : g_bad_thresh
    $error("fifo_wptr_full: AFULL_THRESH out of range 1..2**ADDRSIZE");
  end

  logic [ADDRSIZE:0] wbin, wbinnext, wgraynext, rbin_s, wcount_next, full_cmp;

  gray2bin_conv #(.W(ADDRSIZE + 1)) u_rptr_conv (
    .gray (wq2_rptr),
    .bin  (rbin_s)
  );

  assign wen         = winc & ~wfull;
  assign waddr       = wbin[ADDRSIZE-1:0];
  assign wbinnext    = wbin + {{ADDRSIZE{1'b0}}, wen};
  assign wgraynext   = (wbinnext >> 1) ^ wbinnext;
  assign wcount_next = wbinnext - rbin_s;
  // Full when write Gray equals read Gray with the top two bits inverted.
  assign full_cmp    = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin      <= '0;
      wptr      <= '0;
      wfull     <= 1'b0;
      wcount    <= '0;
      woverflow <= 1'b0;
    end else begin
      wbin      <= wbinnext;
      wptr      <= wgraynext;
      wfull     <= (wgraynext == full_cmp);
      wcount    <= wcount_next;
      woverflow <= woverflow | (winc & wfull);
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) walmost_full <= 1'b0;
    else     walmost_full <= (int'(wcount_next) >= AFULL_THRESH);
  end
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed self-checking bench for fifo_wptr_full (ADDRSIZE=4, AFULL_THRESH=12).
`timescale 1ns/1ps
module tb_fifo_wptr_full;

  logic       clk = 1'b0;
  logic       rst;
  logic       winc;
  logic [4:0] wq2_rptr;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic [4:0] wcount;
  logic       woverflow;
`ifdef FIFO_ALMOST_FULL_EN
  logic       walmost_full;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fifo_wptr_full #(.ADDRSIZE(4), .AFULL_THRESH(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .wen          (wen),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .wcount       (wcount),
`ifdef FIFO_ALMOST_FULL_EN
    .walmost_full (walmost_full),
`endif
    .woverflow    (woverflow)
  );

  function automatic logic [4:0] g(input int x);
    logic [4:0] b;
    b = x[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; winc = 1'b0; wq2_rptr = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // reset with winc held high
    rst = 1'b1; winc = 1'b1; wq2_rptr = '0;
    #3;
    chk("rst_wptr", wptr, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wcount", wcount, 0);
    chk("rst_wfull", wfull, 0);
    chk("rst_wovf", woverflow, 0);
    chk("rst_wen", wen, 1);
    tick();
    rst = 1'b0;
    tick();
    chk("first_waddr", waddr, 1);
    chk("first_wptr", wptr, 5'b00001);
    chk("first_wcount", wcount, 1);

    // fill 16 slots with the read pointer parked at 0
    do_reset();
    winc = 1'b1;
    repeat (15) tick();
    chk("fill15_wfull", wfull, 0);
    chk("fill15_wcount", wcount, 15);
    tick();
    chk("fill16_wfull", wfull, 1);
    chk("fill16_wptr", wptr, 5'b11000);
    chk("fill16_wcount", wcount, 5'b10000);
    chk("ovf_before", woverflow, 0);
    chk("full_wen", wen, 0);
    tick();
    chk("ovf_wptr_hold", wptr, 5'b11000);
    chk("ovf_waddr_hold", waddr, 0);
    chk("ovf_flag", woverflow, 1);
    chk("ovf_still_full", wfull, 1);

    // drain release
    winc = 1'b0; wq2_rptr = 5'b00001;
    tick();
    chk("drain_wfull", wfull, 0);
    chk("drain_wcount", wcount, 15);
    chk("drain_ovf_sticky", woverflow, 1);

    // continuous write + read, 40 writes, read lagging by one
    do_reset();
    for (int k = 0; k < 40; k++) begin
      int rb;
      rb = (k > 0) ? k - 1 : 0;
      winc = 1'b1;
      wq2_rptr = g(rb);
      tick();
      chk($sformatf("wrap_wptr_%0d", k), wptr, g(k + 1));
      chk($sformatf("wrap_wcount_%0d", k), wcount, (k + 1 - rb) & 31);
    end
    winc = 1'b0;
    chk("wrap_final_wptr", wptr, 5'b01100);
    chk("wrap_wfull", wfull, 0);
    chk("wrap_ovf", woverflow, 0);

`ifdef FIFO_ALMOST_FULL_EN
    do_reset();
    winc = 1'b1;
    repeat (11) tick();
    chk("af11", walmost_full, 0);
    tick();
    chk("af12", walmost_full, 1);
    winc = 1'b0; wq2_rptr = 5'b00001;
    tick();
    chk("af_release", walmost_full, 0);
    chk("af_release_wcount", wcount, 11);
`endif

    // async reset mid-burst
    do_reset();
    winc = 1'b1;
    repeat (9) tick();
    chk("mid_wcount", wcount, 9);
    chk("mid_wptr", wptr, g(9));
    #2;
    rst = 1'b1;
    #1;
    chk("async_wptr", wptr, 0);
    chk("async_waddr", waddr, 0);
    chk("async_wcount", wcount, 0);
    chk("async_wfull", wfull, 0);
    chk("async_wovf", woverflow, 0);
    rst = 1'b0; winc = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
